// File: rtl/mux_pkg.sv
// Shared defaults and helpers for the one-hot mux/demux family.
package mux_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_N     = 3;
    localparam int unsigned DEFAULT_ERR_W = 8;

    // Widest select vector the helper accepts; narrower selects are zero-extended.
    localparam int unsigned MAX_N = 32;

    // Returns 1 iff exactly one bit of sel is set.
    function automatic logic onehot_check(input logic [MAX_N-1:0] sel);
        int unsigned ones;
        ones = 0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            ones += int'(sel[i]);
        end
        return (ones == 1);
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry valid/ready holding register for a single demux output channel.
module demux_slot #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             free
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Next state: load wins, otherwise a consumed word drops valid and keeps stale data.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Holding register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    // Slot can accept when empty or being drained this cycle.
    assign free      = !valid_q || out_ready;

endmodule

// File: rtl/demux_generic.sv
// Registered one-hot demultiplexer: one valid/ready stream fanned out to N
// held output channels; malformed selects are dropped and counted.
module demux_generic
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned N         = DEFAULT_N,
    parameter int unsigned ERR_CNT_W = DEFAULT_ERR_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [N-1:0]              in_sel,
    output logic [N-1:0]              out_valid,
    input  logic [N-1:0]              out_ready,
    output logic [N-1:0][WIDTH-1:0]   out_data,
    output logic                      err_pulse,
    output logic [ERR_CNT_W-1:0]      err_count
);

    logic [MAX_N-1:0]     sel_ext;
    logic                 sel_ok;
    logic [N-1:0]         slot_free;
    logic [N-1:0]         load;
    logic                 err_pulse_q, err_pulse_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    // Select classification and acceptance; in_ready never looks at in_valid.
    always_comb begin
        sel_ext           = '0;
        sel_ext[N-1:0]    = in_sel;
        sel_ok            = onehot_check(sel_ext);
        in_ready          = 1'b1;
        if (sel_ok) begin
            in_ready = |(in_sel & slot_free);
        end
        load = {N{in_valid && sel_ok}} & in_sel & slot_free;
    end

    for (genvar k = 0; k < N; k++) begin : g_slot
        demux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .load_data (in_data),
            .out_ready (out_ready[k]),
            .out_valid (out_valid[k]),
            .out_data  (out_data[k]),
            .free      (slot_free[k])
        );
    end

    // Drop bookkeeping: pulse on every malformed beat, saturating counter.
    always_comb begin
        err_pulse_d = in_valid && !sel_ok;
        err_count_d = err_count_q;
        if (err_pulse_d && (err_count_q != '1)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    // Error state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

    a_load_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(load));

endmodule

// File: tb/tb_demux_generic.sv
// Directed bench for demux_generic with hand-computed expectations.
module tb_demux_generic;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned N     = 3;

    logic                    clk;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        in_data;
    logic [N-1:0]            in_sel;
    logic [N-1:0]            out_valid;
    logic [N-1:0]            out_ready;
    logic [N-1:0][WIDTH-1:0] out_data;
    logic                    err_pulse;
    logic [7:0]              err_count;

    logic                    s_in_ready;
    logic [N-1:0]            s_out_valid;
    logic [N-1:0][WIDTH-1:0] s_out_data;
    logic                    s_err_pulse;
    logic [1:0]              s_err_count;

    int n_checks;
    int n_errors;

    demux_generic #(.WIDTH(WIDTH), .N(N), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .err_pulse(err_pulse),
        .err_count(err_count)
    );

    // Same stimulus, 2-bit error counter to exercise saturation.
    demux_generic #(.WIDTH(WIDTH), .N(N), .ERR_CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_sel(in_sel), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_data(s_out_data), .err_pulse(s_err_pulse),
        .err_count(s_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        out_ready = '0;

        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data",  32'(out_data),  32'h0);
        check("rst_err_pulse", 32'(err_pulse), 32'h0);
        check("rst_err_count", 32'(err_count), 32'h0);
        rst_n = 1'b1;

        // 1: single beat
        out_ready = 3'b111;
        in_valid  = 1'b1;
        in_sel    = 3'b010;
        in_data   = 16'hA5A5;
        #1;
        check("s1_in_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        check("s1_out_valid", 32'(out_valid), 32'h2);
        check("s1_out_data1", 32'(out_data[1]), 32'hA5A5);
        tick();
        check("s1_out_valid_drop", 32'(out_valid), 32'h0);

        // 2: backpressure on channel 0
        out_ready = 3'b110;
        in_valid  = 1'b1;
        in_sel    = 3'b001;
        in_data   = 16'h0001;
        #1;
        check("s2_in_ready_first", 32'(in_ready), 32'h1);
        tick();
        in_data = 16'h0002;
        #1;
        check("s2_in_ready_blocked", 32'(in_ready), 32'h0);
        check("s2_out_valid", 32'(out_valid), 32'h1);
        check("s2_out_data0", 32'(out_data[0]), 32'h0001);
        tick();
        check("s2_in_ready_still", 32'(in_ready), 32'h0);
        check("s2_out_data0_stable", 32'(out_data[0]), 32'h0001);
        check("s2_out_valid_stable", 32'(out_valid), 32'h1);
        out_ready = 3'b111;
        #1;
        check("s2_in_ready_release", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        check("s2_out_data0_new", 32'(out_data[0]), 32'h0002);
        check("s2_out_valid_new", 32'(out_valid), 32'h1);
        tick();
        check("s2_drained", 32'(out_valid), 32'h0);

        // 3: streaming full throughput
        out_ready = 3'b111;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_sel   = 3'(1 << (i % 3));
            in_data  = 16'(i);
            #1;
            check($sformatf("s3_in_ready_%0d", i), 32'(in_ready), 32'h1);
            tick();
            check($sformatf("s3_out_valid_%0d", i), 32'(out_valid), 32'(1 << (i % 3)));
            check($sformatf("s3_out_data_%0d", i), 32'(out_data[i % 3]), 32'(i));
        end
        in_valid = 1'b0;
        tick();
        check("s3_drained", 32'(out_valid), 32'h0);

        // 4: malformed selects
        in_valid = 1'b1;
        in_sel   = 3'b000;
        in_data  = 16'hDEAD;
        #1;
        check("s4_in_ready_zero", 32'(in_ready), 32'h1);
        tick();
        check("s4_err_pulse_1", 32'(err_pulse), 32'h1);
        check("s4_err_count_1", 32'(err_count), 32'h1);
        check("s4_out_valid_1", 32'(out_valid), 32'h0);
        in_sel = 3'b011;
        #1;
        check("s4_in_ready_multi", 32'(in_ready), 32'h1);
        tick();
        check("s4_err_pulse_2", 32'(err_pulse), 32'h1);
        check("s4_err_count_2", 32'(err_count), 32'h2);
        check("s4_sat_count_2", 32'(s_err_count), 32'h2);
        check("s4_out_valid_2", 32'(out_valid), 32'h0);
        in_sel = 3'b111;
        tick();
        in_sel = 3'b000;
        tick();
        in_sel = 3'b101;
        tick();
        check("s4_err_count_5", 32'(err_count), 32'h5);
        check("s4_sat_count_sat", 32'(s_err_count), 32'h3);
        check("s4_sat_out_valid", 32'(s_out_valid), 32'h0);
        in_valid = 1'b0;
        tick();
        check("s4_err_pulse_low", 32'(err_pulse), 32'h0);
        check("s4_err_count_hold", 32'(err_count), 32'h5);

        // 5: independent channels, channel 2 stalled
        out_ready = 3'b011;
        in_valid  = 1'b1;
        in_sel    = 3'b100;
        in_data   = 16'hBEEF;
        tick();
        check("s5_ch2_valid", 32'(out_valid), 32'h4);
        in_sel  = 3'b001;
        in_data = 16'h1234;
        #1;
        check("s5_in_ready_ch0", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        check("s5_out_data0", 32'(out_data[0]), 32'h1234);
        check("s5_out_data2", 32'(out_data[2]), 32'hBEEF);
        check("s5_out_valid", 32'(out_valid), 32'h5);
        tick();
        check("s5_ch0_drained", 32'(out_valid), 32'h4);
        check("s5_ch2_held", 32'(out_data[2]), 32'hBEEF);

        // 6: async reset mid-operation with channels 0 and 2 holding
        out_ready = 3'b000;
        in_valid  = 1'b1;
        in_sel    = 3'b001;
        in_data   = 16'h5555;
        tick();
        in_valid = 1'b0;
        check("s6_pre_valid", 32'(out_valid), 32'h5);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_rst_out_valid", 32'(out_valid), 32'h0);
        check("s6_rst_out_data", 32'(out_data), 32'h0);
        check("s6_rst_err_count", 32'(err_count), 32'h0);
        check("s6_rst_sat_count", 32'(s_err_count), 32'h0);
        #1;
        rst_n     = 1'b1;
        out_ready = 3'b111;
        in_valid  = 1'b1;
        in_sel    = 3'b010;
        in_data   = 16'hA5A5;
        #1;
        check("s6_in_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        check("s6_out_valid", 32'(out_valid), 32'h2);
        check("s6_out_data1", 32'(out_data[1]), 32'hA5A5);
        tick();
        check("s6_out_valid_drop", 32'(out_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
